// File: rtl/bit_pattern_pkg.sv
// Shared state encoding for the serial bit-pattern generator and the benches
// that decode its debug state port.
package bit_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } bpg_state_t;

endpackage : bit_pattern_pkg

// File: rtl/bit_shift_reg.sv
// Parallel-in serial-out register: parallel load, shift-left with zero fill,
// MSB tap. Clear and load take priority over shift.
module bit_shift_reg #(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [PAT_W-1:0] i_load_data,
  input  logic             i_shift,
  output logic             o_msb
);

  logic [PAT_W-1:0] r_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_clear) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_load_data;
    end else if (i_shift) begin
      r_sr <= {r_sr[PAT_W-2:0], 1'b0};
    end
  end

  assign o_msb = r_sr[PAT_W-1];

endmodule : bit_shift_reg

// File: rtl/bit_pattern_generator.sv
// Serial bit-pattern transmitter: latches a pattern on start and shifts it out
// MSB-first, with optional repetitions separated by a fixed idle gap.
module bit_pattern_generator
  import bit_pattern_pkg::*;
#(
  parameter int PAT_W   = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam int GAP_W  = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam bit NO_GAP = (GAP_CYC == 0);

  bpg_state_t       r_state;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_bit_cnt;
  logic [REP_W-1:0] r_rep_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_out;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;

  logic [LEN_W-1:0] w_eff_len;
  logic [LEN_W-1:0] w_shamt;
  logic [PAT_W-1:0] w_aligned;
  logic             w_accept;
  logic             w_reload;
  logic             w_sr_clear;
  logic             w_sr_load;
  logic             w_sr_shift;
  logic [PAT_W-1:0] w_sr_data;
  logic             w_msb;

  // Left-align the active field so the first bit to send sits in the MSB.
  assign w_eff_len = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
  assign w_shamt   = LEN_W'(PAT_W) - w_eff_len;
  assign w_aligned = pattern << w_shamt;

  assign w_accept   = (r_state == IDLE) && start && !abort && (w_eff_len != '0);
  assign w_reload   = !abort &&
                      (((r_state == SHIFT) && (r_bit_cnt == '0) && (r_rep_cnt != '0) && NO_GAP) ||
                       ((r_state == GAP) && (r_gap_cnt == '0)));
  assign w_sr_clear = abort && (r_state != IDLE);
  assign w_sr_load  = w_accept || w_reload;
  assign w_sr_shift = !abort && (r_state == SHIFT) && (r_bit_cnt != '0);
  // The shifter holds the bits after the one currently on out.
  assign w_sr_data  = w_accept ? (w_aligned << 1) : (r_pat << 1);

  bit_shift_reg #(
    .PAT_W (PAT_W)
  ) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_sr_clear),
    .i_load      (w_sr_load),
    .i_load_data (w_sr_data),
    .i_shift     (w_sr_shift),
    .o_msb       (w_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pat       <= '0;
      r_len       <= '0;
      r_bit_cnt   <= '0;
      r_rep_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort && (r_state != IDLE)) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_rep_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_pat     <= w_aligned;
            r_len     <= w_eff_len;
            r_rep_cnt <= reps;
            r_busy    <= 1'b1;
            if (w_eff_len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= SHIFT;
              r_out       <= w_aligned[PAT_W-1];
              r_out_valid <= 1'b1;
              r_bit_cnt   <= w_eff_len - LEN_W'(1);
            end
          end
        end
        SHIFT: begin
          if (r_bit_cnt != '0) begin
            r_out     <= w_msb;
            r_bit_cnt <= r_bit_cnt - LEN_W'(1);
          end else if (r_rep_cnt != '0) begin
            r_rep_cnt <= r_rep_cnt - REP_W'(1);
            if (NO_GAP) begin
              r_out     <= r_pat[PAT_W-1];
              r_bit_cnt <= r_len - LEN_W'(1);
            end else begin
              r_state     <= GAP;
              r_gap_cnt   <= GAP_W'(GAP_CYC - 1);
              r_out       <= 1'b0;
              r_out_valid <= 1'b0;
            end
          end else begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end
        GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end else begin
            r_state     <= SHIFT;
            r_out       <= r_pat[PAT_W-1];
            r_out_valid <= 1'b1;
            r_bit_cnt   <= r_len - LEN_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign state     = r_state;

endmodule : bit_pattern_generator

// File: tb/tb_bit_pattern_generator.sv
// Directed bench for bit_pattern_generator: linear steps with hand-computed
// expected bit streams, checked by immediate assertions.
module tb_bit_pattern_generator;
  import bit_pattern_pkg::*;

  localparam int PAT_W   = 8;
  localparam int LEN_W   = 4;
  localparam int REP_W   = 4;
  localparam int GAP_CYC = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] reps;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  int n_tests = 0;
  int n_fail  = 0;

  bit_pattern_generator #(
    .PAT_W   (PAT_W),
    .LEN_W   (LEN_W),
    .REP_W   (REP_W),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .len       (len),
    .reps      (reps),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_start(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                            input logic [REP_W-1:0] r);
    pattern = p;
    len     = l;
    reps    = r;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Checks n serial bits, bits[n-1] first; optionally pulses start at index glitch.
  task automatic expect_frame(input logic [31:0] bits, input int n, input int glitch,
                              input string tag);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_bit%0d", tag, i), {31'd0, out}, {31'd0, bits[n-1-i]});
      check($sformatf("%s_vld%0d", tag, i), {31'd0, out_valid}, 32'd1);
      if (i == glitch) begin
        start   = 1'b1;
        pattern = ~pattern;
      end
      tick();
      start = 1'b0;
    end
    $display("[TB] frame %s: %0d bits checked", tag, n);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    len     = '0;
    reps    = '0;
    tick();
    tick();
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset mid-frame after 3 bits of A5 = 10100101
    send_start(8'hA5, 4'd8, 4'd0);
    expect_frame(32'b101, 3, -1, "rstmid");
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_out", {31'd0, out}, 32'd0);
    check("rstmid_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_state", {30'd0, state}, 32'd0);
    check("rstmid_done", {31'd0, done}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rstmid_nodone", {31'd0, done}, 32'd0);
    check("rstmid_idle", {30'd0, state}, 32'd0);

    // Single frame, len=3 of 8'b0000_0010 -> 0,1,0
    send_start(8'b0000_0010, 4'd3, 4'd0);
    check("single_state", {30'd0, state}, 32'd1);
    check("single_busy", {31'd0, busy}, 32'd1);
    expect_frame(32'b010, 3, -1, "single");
    check("single_done", {31'd0, done}, 32'd1);
    check("single_dstate", {30'd0, state}, 32'd3);
    check("single_dvalid", {31'd0, out_valid}, 32'd0);
    check("single_dbusy", {31'd0, busy}, 32'd1);
    tick();
    check("single_idle", {30'd0, state}, 32'd0);
    check("single_ibusy", {31'd0, busy}, 32'd0);
    check("single_idone", {31'd0, done}, 32'd0);

    // Three copies of C3 with 2-cycle gaps; inputs changed after acceptance
    send_start(8'hC3, 4'd8, 4'd2);
    pattern = 8'h00;
    len     = 4'd2;
    reps    = 4'd0;
    for (int f = 0; f < 3; f++) begin
      expect_frame(32'hC3, 8, -1, $sformatf("rep%0d", f));
      if (f < 2) begin
        for (int g = 0; g < GAP_CYC; g++) begin
          check($sformatf("gap%0d_%0d_out", f, g), {31'd0, out}, 32'd0);
          check($sformatf("gap%0d_%0d_vld", f, g), {31'd0, out_valid}, 32'd0);
          check($sformatf("gap%0d_%0d_st", f, g), {30'd0, state}, 32'd2);
          tick();
        end
      end
    end
    check("rep_done29", {31'd0, done}, 32'd1);
    check("rep_dstate", {30'd0, state}, 32'd3);
    tick();
    check("rep_idle", {30'd0, state}, 32'd0);
    check("rep_ibusy", {31'd0, busy}, 32'd0);

    // len=0: done at T+1, nothing sent
    send_start(8'hFF, 4'd0, 4'd3);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_valid", {31'd0, out_valid}, 32'd0);
    check("len0_state", {30'd0, state}, 32'd3);
    tick();
    check("len0_idle", {30'd0, state}, 32'd0);
    check("len0_valid2", {31'd0, out_valid}, 32'd0);

    // len=12 clamps to 8: 96 = 10010110
    send_start(8'h96, 4'd12, 4'd0);
    expect_frame(32'h96, 8, -1, "len12");
    check("len12_done", {31'd0, done}, 32'd1);
    tick();
    check("len12_idle", {30'd0, state}, 32'd0);

    // Abort in the second gap cycle: 0B len 4 -> 1011
    send_start(8'h0B, 4'd4, 4'd1);
    expect_frame(32'b1011, 4, -1, "abort");
    check("abort_gap1", {30'd0, state}, 32'd2);
    tick();
    check("abort_gap2", {30'd0, state}, 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_state", {30'd0, state}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    tick();
    check("abort_nodone", {31'd0, done}, 32'd0);
    check("abort_idle", {30'd0, state}, 32'd0);

    // start pulsed mid-frame is ignored: 5A = 01011010
    send_start(8'h5A, 4'd8, 4'd0);
    expect_frame(32'h5A, 8, 2, "ignst");
    check("ignst_done", {31'd0, done}, 32'd1);
    tick();
    check("ignst_idle", {30'd0, state}, 32'd0);

    // start and abort together in IDLE: abort wins
    pattern = 8'hFF;
    len     = 4'd4;
    start   = 1'b1;
    abort   = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("stab_state", {30'd0, state}, 32'd0);
    check("stab_busy", {31'd0, busy}, 32'd0);
    tick();
    check("stab_state2", {30'd0, state}, 32'd0);

    // Back-to-back: start in the cycle right after DONE
    send_start(8'h03, 4'd2, 4'd0);
    expect_frame(32'b11, 2, -1, "b2b_a");
    check("b2b_done_a", {31'd0, done}, 32'd1);
    tick();
    check("b2b_idle", {30'd0, state}, 32'd0);
    send_start(8'h02, 4'd2, 4'd0);
    check("b2b_state", {30'd0, state}, 32'd1);
    expect_frame(32'b10, 2, -1, "b2b_b");
    check("b2b_done_b", {31'd0, done}, 32'd1);
    tick();
    check("b2b_end", {30'd0, state}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bit_pattern_generator
